// File: rtl/gf163_pkg.sv
// Shared definitions for the GF(2^163) inversion sequencer.
//   M      : field degree, width of every operand bus
//   ITER   : core operations per inversion (M-1)
//   CNT_W  : iteration counter width (2^CNT_W > ITER)
//   F      : reduction polynomial x^163 + x^7 + x^6 + x^3 + 1
//   state_t: sequencer states
//   ONE    : the field element 1
package gf163_pkg;

  localparam int unsigned M     = 163;
  localparam int unsigned ITER  = M - 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [M:0] F = (164'd1 << 163) | 164'h0C9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN
  } state_t;

  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

endpackage

// File: rtl/gf163_inv_seq.sv
// GF(2^163) field inversion sequencer (Fermat: a^-1 = a^(2^163-2)).
// Drives an external multiply-then-square core ITER times, computing
// s_{k+1} = (s_k * a)^2 with s_1 = 1; after ITER ops s = a^-1.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, a_in         : one-cycle request and operand (accepted in IDLE only)
//   busy, done, result  : status, one-cycle completion pulse, inverse
//   zero_err            : a_in was zero (ZERO_CHECK_EN builds only, else 0)
//   acb_enable          : one-cycle start pulse to the core
//   acb_configuration   : core mode, held 0 (square of product)
//   acb_a, acb_b        : core operands (s register, captured a)
//   acb_c, acb_done     : core result and completion level
//
// Build option: define ZERO_CHECK_EN to short-circuit a zero operand
// straight to completion with zero_err set and no core operations.
module gf163_inv_seq
  import gf163_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result,
  output logic         zero_err,
  output logic         acb_enable,
  output logic         acb_configuration,
  output logic [M-1:0] acb_a,
  output logic [M-1:0] acb_b,
  input  logic [M-1:0] acb_c,
  input  logic         acb_done
);

  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

  state_t           st_q, st_d;
  logic [M-1:0]     s_q, s_d;
  logic [M-1:0]     a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [M-1:0]     result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  // High during the first WAIT cycle, when acb_done may still be the
  // level left over from the previous operation.
  logic             guard_q, guard_d;
`ifdef ZERO_CHECK_EN
  logic             zerr_q, zerr_d;
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    st_d     = st_q;
    s_d      = s_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    en_d     = 1'b0;
    guard_d  = 1'b0;
`ifdef ZERO_CHECK_EN
    zerr_d   = zerr_q;
`endif
    case (st_q)
      IDLE: begin
        if (start) begin
          a_d    = a_in;
          s_d    = ONE;
          cnt_d  = '0;
          busy_d = 1'b1;
`ifdef ZERO_CHECK_EN
          zerr_d = 1'b0;
          if (a_in == '0) begin
            st_d     = FIN;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = '0;
            zerr_d   = 1'b1;
          end else begin
            st_d = ISSUE;
            en_d = 1'b1;
          end
`else
          st_d = ISSUE;
          en_d = 1'b1;
`endif
        end
      end
      ISSUE: begin
        st_d    = WAIT;
        guard_d = 1'b1;
      end
      WAIT: begin
        if (!guard_q && acb_done) begin
          s_d   = acb_c;
          cnt_d = cnt_inc;
          if (cnt_inc == ITER_C) begin
            // Outputs are registered, so result/done are loaded on entry
            // to FIN to be visible during the FIN cycle itself.
            st_d     = FIN;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = acb_c;
          end else begin
            st_d = ISSUE;
            en_d = 1'b1;
          end
        end
      end
      FIN: begin
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      s_q      <= ONE;
      a_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      guard_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      s_q      <= s_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      guard_q  <= guard_d;
    end
  end

`ifdef ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) zerr_q <= 1'b0;
    else     zerr_q <= zerr_d;
  end
  assign zero_err = zerr_q;
`else
  assign zero_err = 1'b0;
`endif

  assign busy              = busy_q;
  assign done              = done_q;
  assign result            = result_q;
  assign acb_enable        = en_q;
  assign acb_configuration = 1'b0;
  assign acb_a             = s_q;
  assign acb_b             = a_q;

endmodule

// File: tb/tb_gf163_inv_seq.sv
// Self-checking bench for gf163_inv_seq with a behavioural multiply-square
// core of configurable per-operation latency and an independent GF(2^163)
// reference multiplier.
module tb_gf163_inv_seq;
  import gf163_pkg::*;

  localparam logic [M-1:0] POLY = F[M-1:0];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [M-1:0] a_in;
  logic         busy, done, zero_err, acb_enable, acb_configuration;
  logic [M-1:0] result, acb_a, acb_b;
  logic [M-1:0] acb_c;
  logic         acb_done;

  gf163_inv_seq dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .a_in             (a_in),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .zero_err         (zero_err),
    .acb_enable       (acb_enable),
    .acb_configuration(acb_configuration),
    .acb_a            (acb_a),
    .acb_b            (acb_b),
    .acb_c            (acb_c),
    .acb_done         (acb_done)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] acc;
    logic [M-1:0] t;
    acc = '0;
    t   = x;
    for (int unsigned i = 0; i < M; i++) begin
      if (y[i]) acc ^= t;
      t = t[M-1] ? ((t << 1) ^ POLY) : (t << 1);
    end
    return acc;
  endfunction

  // Behavioural core. In stale mode acb_done is left high for one cycle
  // after the enable, with acb_c still holding the previous product.
  int unsigned  lmin = 1, lmax = 1;
  bit           stale_mode = 1'b0;
  int unsigned  core_cnt;
  logic [M-1:0] core_a, core_b;

  always @(posedge clk) begin
    if (rst) begin
      acb_done <= 1'b0;
      core_cnt <= 0;
      acb_c    <= '0;
    end else if (acb_enable) begin
      if (!stale_mode) acb_done <= 1'b0;
      core_a   <= acb_a;
      core_b   <= acb_b;
      core_cnt <= $urandom_range(lmax, lmin);
    end else if (core_cnt > 1) begin
      acb_done <= 1'b0;
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      acb_done <= 1'b1;
      acb_c    <= gf_mul(gf_mul(core_a, core_b), gf_mul(core_a, core_b));
      core_cnt <= 0;
    end
  end

  int unsigned en_cnt = 0, done_cnt = 0, cfg_err = 0;
  always @(posedge clk) begin
    if (acb_enable) en_cnt++;
    if (done) done_cnt++;
    if (acb_configuration !== 1'b0) cfg_err++;
  end

  int unsigned n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam int unsigned LIMIT = 40000;

  // One inversion: returns result, posedges from accept edge to done,
  // enable/done pulse counts, zero_err at done, busy and result in the
  // cycle after accept.
  task automatic run_inv(input logic [M-1:0] a, input int unsigned lo, input int unsigned hi,
                         input bit stale, input bit spam,
                         output logic [M-1:0] res, output int unsigned lat,
                         output int unsigned nen, output int unsigned ndone,
                         output logic zerr, output logic busy0, output logic [M-1:0] res0);
    int unsigned en0, dn0;
    @(negedge clk);
    lmin = lo; lmax = hi; stale_mode = stale;
    a_in = a; start = 1'b1;
    en0 = en_cnt; dn0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    res0  = result;
    lat   = 0;
    while (!done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
      start = spam && (lat % 5 == 0) && !done;
    end
    start = 1'b0;
    if (!done) check_val("done_timeout", M'(lat), M'(0));
    res  = result;
    zerr = zero_err;
    @(posedge clk); #1;
    check_val("done_one_cycle", M'(done), M'(0));
    nen   = en_cnt - en0;
    ndone = done_cnt - dn0;
  endtask

  logic [M-1:0] res, res0, a, x_inv;
  int unsigned  lat, nen, ndone, l, en0, dn0, w;
  logic         zerr, busy0;

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", M'(busy), M'(0));
    check_val("rst_done", M'(done), M'(0));
    check_val("rst_result", result, '0);
    check_val("rst_zero_err", M'(zero_err), M'(0));
    check_val("rst_acb_enable", M'(acb_enable), M'(0));
    check_val("rst_acb_a", acb_a, M'(1));
    check_val("rst_acb_b", acb_b, '0);
    @(negedge clk); rst = 1'b0;

    // a=1, Lcore=1: 1 + 162*3 + 1 = 488 cycles including accept and FIN
    run_inv(M'(1), 1, 1, 1'b0, 1'b0, res, lat, nen, ndone, zerr, busy0, res0);
    check_val("one_result", res, M'(1));
    check_val("one_total_cycles", M'(lat + 2), M'(488));
    check_val("one_enables", M'(nen), M'(162));
    check_val("one_done_pulses", M'(ndone), M'(1));
    check_val("one_busy_after_accept", M'(busy0), M'(1));

    // a=x: inverse is x^162 + x^6 + x^5 + x^2
    x_inv = (M'(1) << 162) | M'(8'h64);
    run_inv(M'(2), 2, 2, 1'b0, 1'b0, res, lat, nen, ndone, zerr, busy0, res0);
    check_val("x_result_held_on_start", res0, M'(1));
    check_val("x_result", res, x_inv);
    check_val("x_inverse_product", gf_mul(res, M'(2)), M'(1));
    check_val("x_total_cycles", M'(lat + 2), M'(1 + 162 * 4 + 1));

    // random operands, random per-op latency
    for (int unsigned k = 0; k < 3; k++) begin
      a = '0;
      for (int unsigned j = 0; j < 6; j++) a = (a << 32) | M'($urandom);
      if (a == '0) a = M'(1);
      run_inv(a, 1, 12, 1'b0, 1'b0, res, lat, nen, ndone, zerr, busy0, res0);
      check_val("rand_inverse_product", gf_mul(res, a), M'(1));
      check_val("rand_enables", M'(nen), M'(162));
    end

    // stale acb_done across the guard cycle, fixed latency 3
    a = M'(64'hDEAD_BEEF_0123_4567) ^ (M'(1) << 150);
    run_inv(a, 3, 3, 1'b1, 1'b0, res, lat, nen, ndone, zerr, busy0, res0);
    check_val("stale_inverse_product", gf_mul(res, a), M'(1));
    check_val("stale_total_cycles", M'(lat + 2), M'(1 + 162 * 5 + 1));
    check_val("stale_enables", M'(nen), M'(162));

    // start pulsed repeatedly while busy
    a = M'(64'h1234_5678_9ABC_DEF1);
    run_inv(a, 1, 1, 1'b0, 1'b1, res, lat, nen, ndone, zerr, busy0, res0);
    check_val("spam_inverse_product", gf_mul(res, a), M'(1));
    check_val("spam_enables", M'(nen), M'(162));
    check_val("spam_done_pulses", M'(ndone), M'(1));
    check_val("spam_total_cycles", M'(lat + 2), M'(488));
    en0 = en_cnt; dn0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check_val("spam_no_extra_enable", M'(en_cnt - en0), M'(0));
    check_val("spam_no_extra_done", M'(done_cnt - dn0), M'(0));

    // reset at iteration 80
    @(negedge clk);
    lmin = 1; lmax = 1; stale_mode = 1'b0;
    a_in = M'(5); start = 1'b1;
    en0 = en_cnt; dn0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while ((en_cnt - en0) < 80 && w < LIMIT) begin
      @(posedge clk); #1;
      w++;
    end
    check_val("rst_mid_reached_80", M'(en_cnt - en0), M'(80));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_busy", M'(busy), M'(0));
    check_val("rst_mid_done", M'(done), M'(0));
    check_val("rst_mid_enable", M'(acb_enable), M'(0));
    check_val("rst_mid_result", result, '0);
    @(negedge clk); rst = 1'b0;
    en0 = en_cnt;
    repeat (30) @(posedge clk);
    #1;
    check_val("rst_mid_no_enable", M'(en_cnt - en0), M'(0));
    check_val("rst_mid_no_done", M'(done_cnt - dn0), M'(0));
    a = M'(5);
    run_inv(a, 1, 3, 1'b0, 1'b0, res, lat, nen, ndone, zerr, busy0, res0);
    check_val("post_rst_inverse_product", gf_mul(res, a), M'(1));
    check_val("post_rst_enables", M'(nen), M'(162));

    // zero operand
    run_inv('0, 1, 1, 1'b0, 1'b0, res, lat, nen, ndone, zerr, busy0, res0);
    check_val("zero_result", res, '0);
    check_val("zero_done_pulses", M'(ndone), M'(1));
`ifdef ZERO_CHECK_EN
    check_val("zero_total_cycles", M'(lat + 2), M'(2));
    check_val("zero_enables", M'(nen), M'(0));
    check_val("zero_err_set", M'(zerr), M'(1));
    repeat (5) @(posedge clk);
    #1;
    check_val("zero_err_holds", M'(zero_err), M'(1));
`else
    check_val("zero_total_cycles", M'(lat + 2), M'(488));
    check_val("zero_enables", M'(nen), M'(162));
    check_val("zero_err_low", M'(zerr), M'(0));
`endif
    a = M'(3);
    run_inv(a, 1, 2, 1'b0, 1'b0, res, lat, nen, ndone, zerr, busy0, res0);
    check_val("after_zero_inverse_product", gf_mul(res, a), M'(1));
    check_val("after_zero_err_cleared", M'(zerr), M'(0));
    check_val("configuration_never_set", M'(cfg_err), M'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
